// File: rtl/fc_feeder.sv
// Initiator side of the FC layer handshake: gathers N_IN feature words, raises a
// level enable until fc_done, then offers the captured result on a valid/ready port.
module fc_feeder #(
  parameter int N_IN    = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N_IN*DW-1:0] fc_input,
  output logic               fc_enable,
  input  logic               fc_done,
  input  logic [DW-1:0]      fc_result,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic [CW-1:0]          cnt_q;
  logic [N_IN-1:0][DW-1:0] words_q;

  logic accept, last, done_hit, to_hit;

  assign last     = (idx_q == IW'(N_IN - 1));
  assign in_ready = (state_q == S_FILL);
  assign busy     = !((state_q == S_FILL) && (idx_q == '0));
  assign fc_input = words_q;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_hit = 1'b0;
    to_hit   = 1'b0;
    unique case (state_q)
      S_FILL: begin
        if (in_valid) begin
          accept = 1'b1;
          if (last) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // fc_done takes priority over an expiring wait on the same edge
        if (fc_done) begin
          done_hit = 1'b1;
          state_d  = S_OUT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_d = S_FILL;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // The feature buffer is reset along with everything else so a reset
  // mid-fill leaves no stale words visible on fc_input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
      fc_enable   <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      fc_enable <= (state_d == S_WAIT);
      out_valid <= (state_d == S_OUT);
      if (accept) begin
        words_q[idx_q] <= in_data;
        idx_q          <= last ? '0 : idx_q + 1'b1;
      end
      if (state_q == S_WAIT) cnt_q <= (done_hit || to_hit) ? '0 : cnt_q + 1'b1;
      if (done_hit) out_data <= fc_result;
      if (to_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_feeder.sv
// Directed bench for fc_feeder (N_IN=8, DW=32, TIMEOUT=4): fill, backpressure,
// done/timeout collision, signed data, timeout and reset mid-fill.
module tb_fc_feeder;

  localparam int N_IN = 8;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW-1:0]      in_data;
  logic               in_valid;
  logic               in_ready;
  logic [N_IN*DW-1:0] fc_input;
  logic               fc_enable;
  logic               fc_done;
  logic [DW-1:0]      fc_result;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               timeout_err;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] words [N_IN];

  fc_feeder #(.N_IN(N_IN), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fc_input(fc_input), .fc_enable(fc_enable), .fc_done(fc_done), .fc_result(fc_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams words[] back to back; the last word is accepted on the final edge.
  task automatic feed_batch();
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < N_IN; i++) begin
      total++;
      if (fc_input[i*DW +: DW] !== words[i])
        $display("FAIL %s word%0d got=%h exp=%h", tag, i, fc_input[i*DW +: DW], words[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_valid = 1'b0; fc_done = 1'b0; fc_result = '0; out_ready = 1'b0;
    #12;
    total++; if (fc_enable !== 1'b0)   $display("FAIL rst_en got=%b exp=0", fc_enable);     else passed++;
    total++; if (out_valid !== 1'b0)   $display("FAIL rst_ov got=%b exp=0", out_valid);     else passed++;
    total++; if (out_data !== '0)      $display("FAIL rst_od got=%h exp=0", out_data);      else passed++;
    total++; if (fc_input !== '0)      $display("FAIL rst_fi got=%h exp=0", fc_input);      else passed++;
    total++; if (in_ready !== 1'b1)    $display("FAIL rst_ir got=%b exp=1", in_ready);      else passed++;
    total++; if (busy !== 1'b0)        $display("FAIL rst_busy got=%b exp=0", busy);        else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL rst_te got=%b exp=0", timeout_err);   else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < N_IN; i++) words[i] = DW'(i + 1);
    in_valid = 1'b1; in_data = words[0];
    tick();
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else passed++;
    for (int i = 1; i < N_IN; i++) begin
      in_data = words[i];
      tick();
    end
    in_valid = 1'b0;
    total++; if (fc_enable !== 1'b1) $display("FAIL basic_en1 got=%b exp=1", fc_enable); else passed++;
    total++; if (in_ready !== 1'b0)  $display("FAIL basic_ir got=%b exp=0", in_ready);   else passed++;
    check_words("basic");
    tick();
    total++; if (fc_enable !== 1'b1) $display("FAIL basic_en2 got=%b exp=1", fc_enable); else passed++;
    fc_done = 1'b1; fc_result = 32'd36;
    tick();
    fc_done = 1'b0;
    total++; if (fc_enable !== 1'b0) $display("FAIL basic_en3 got=%b exp=0", fc_enable); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL basic_ov got=%b exp=1", out_valid);  else passed++;
    total++; if (out_data !== 32'd36) $display("FAIL basic_od got=%0d exp=36", out_data); else passed++;
    tick(); tick();
    total++; if (out_valid !== 1'b1) $display("FAIL basic_hold got=%b exp=1", out_valid); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_ov0 got=%b exp=0", out_valid); else passed++;
    total++; if (busy !== 1'b0)      $display("FAIL basic_idle got=%b exp=0", busy);     else passed++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1; in_data = 32'h10 + DW'(i);
      tick();
      in_valid = 1'b0;
      if (i < N_IN - 1) tick();
    end
    total++; if (fc_enable !== 1'b1) $display("FAIL bp_en got=%b exp=1", fc_enable); else passed++;
    fc_done = 1'b1; fc_result = 32'h55;
    tick();
    fc_done = 1'b0;
    total++; if (out_data !== 32'h55) $display("FAIL bp_od got=%h exp=55", out_data); else passed++;
    in_valid = 1'b1; in_data = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      total++; if (in_ready !== 1'b0)  $display("FAIL bp_ir%0d got=%b exp=0", c, in_ready);  else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_ov%0d got=%b exp=1", c, out_valid); else passed++;
      tick();
    end
    total++; if (fc_input[DW-1:0] !== 32'h10) $display("FAIL bp_keep got=%h exp=10", fc_input[DW-1:0]); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_fill got=%b exp=1", in_ready); else passed++;
    // the held word is taken as slot 0 of the next batch
    words[0] = 32'hDEAD;
    for (int i = 1; i < N_IN; i++) words[i] = 32'h20 + DW'(i);
    tick();
    total++; if (fc_input[DW-1:0] !== 32'hDEAD) $display("FAIL bp_slot0 got=%h exp=dead", fc_input[DW-1:0]); else passed++;
    total++; if (fc_input[2*DW-1:DW] !== 32'h11) $display("FAIL bp_slot1old got=%h exp=11", fc_input[2*DW-1:DW]); else passed++;
    for (int i = 1; i < N_IN; i++) begin
      in_data = words[i];
      tick();
    end
    in_valid = 1'b0;
    check_words("bp");
  endtask

  // Continues from the WAIT entered at the end of the backpressure batch.
  task automatic test_collision();
    for (int c = 0; c < 3; c++) tick();
    total++; if (fc_enable !== 1'b1) $display("FAIL col_en got=%b exp=1", fc_enable); else passed++;
    fc_done = 1'b1; fc_result = 32'h77;
    tick();
    fc_done = 1'b0;
    total++; if (out_valid !== 1'b1)   $display("FAIL col_ov got=%b exp=1", out_valid);     else passed++;
    total++; if (out_data !== 32'h77)  $display("FAIL col_od got=%h exp=77", out_data);     else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL col_te got=%b exp=0", timeout_err);   else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_signed();
    words[0] = 32'h8000_0000;
    words[1] = 32'hFFFF_FFFF;
    for (int i = 2; i < N_IN; i++) words[i] = DW'(i);
    feed_batch();
    check_words("sgn");
    fc_done = 1'b1; fc_result = -32'sd5;
    tick();
    fc_done = 1'b0;
    total++; if (out_data !== 32'hFFFF_FFFB) $display("FAIL sgn_od got=%h exp=fffffffb", out_data); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < N_IN; i++) words[i] = 32'h40 + DW'(i);
    feed_batch();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (fc_enable !== 1'b1) $display("FAIL to_en%0d got=%b exp=1", c, fc_enable); else passed++;
    end
    tick();
    total++; if (fc_enable !== 1'b0)   $display("FAIL to_drop got=%b exp=0", fc_enable);   else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL to_te got=%b exp=1", timeout_err);   else passed++;
    total++; if (out_valid !== 1'b0)   $display("FAIL to_ov got=%b exp=0", out_valid);     else passed++;
    total++; if (in_ready !== 1'b1)    $display("FAIL to_ir got=%b exp=1", in_ready);      else passed++;
    fc_done = 1'b1; fc_result = 32'h99;
    tick(); tick();
    fc_done = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL to_stray got=%b exp=0", out_valid); else passed++;
    total++; if (out_data !== 32'hFFFF_FFFB) $display("FAIL to_odkeep got=%h exp=fffffffb", out_data); else passed++;
    for (int i = 0; i < N_IN; i++) words[i] = 32'h60 + DW'(i);
    feed_batch();
    check_words("to_next");
    fc_done = 1'b1; fc_result = 32'h123;
    tick();
    fc_done = 1'b0;
    total++; if (out_data !== 32'h123)  $display("FAIL to_next_od got=%h exp=123", out_data); else passed++;
    total++; if (timeout_err !== 1'b1)  $display("FAIL to_sticky got=%b exp=1", timeout_err); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midfill();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hE0 + DW'(i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    total++; if (busy !== 1'b0)        $display("FAIL mr_busy got=%b exp=0", busy);        else passed++;
    total++; if (fc_input !== '0)      $display("FAIL mr_fi got=%h exp=0", fc_input);      else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL mr_te got=%b exp=0", timeout_err);   else passed++;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < N_IN; i++) words[i] = 32'hA0 + DW'(i);
    feed_batch();
    check_words("mr");
    fc_done = 1'b1; fc_result = 32'h5A5;
    tick();
    fc_done = 1'b0;
    total++; if (out_data !== 32'h5A5) $display("FAIL mr_od got=%h exp=5a5", out_data); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    for (int i = 0; i < N_IN; i++) words[i] = 32'hC0 + DW'(i);
    feed_batch();
    total++; if (fc_enable !== 1'b1) $display("FAIL rw_en got=%b exp=1", fc_enable); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (fc_enable !== 1'b0) $display("FAIL rw_drop got=%b exp=0", fc_enable); else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_collision();
    test_signed();
    test_timeout();
    test_reset_midfill();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
